// File: rtl/pe_add_requant.sv
// pe_add_requant: narrowing back-end for the PE element-wise add datapath.
// Each wide lane gets an arithmetic right shift with round-half-up. The result is
// then saturated to signed DATA_WIDTH. The block is a 2-stage elastic valid/ready
// pipeline and keeps a sticky count of delivered beats that contained a clamped lane.
// Optional feature: define PE_REQUANT_RELU_EN to add the i_relu_en port. When that
// port is 1 for a beat, negative lanes of that beat are zeroed before the shift.
module pe_add_requant #(
    parameter int DATA_WIDTH  = 8,
    parameter int DATA_COPIES = 32,
    parameter int SHIFT_W     = 4,
    parameter int CNT_W       = 16
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic [DATA_COPIES*2*DATA_WIDTH-1:0] i_in_data,
    input  logic                                i_in_vld,
    output logic                                o_in_rdy,
    input  logic [SHIFT_W-1:0]                  i_shift,
    output logic [DATA_COPIES*DATA_WIDTH-1:0]   o_out_data,
    output logic [DATA_COPIES-1:0]              o_out_sat,
    output logic                                o_out_vld,
    input  logic                                i_out_rdy,
    input  logic                                i_sat_clr,
`ifdef PE_REQUANT_RELU_EN
    input  logic                                i_relu_en,
`endif
    output logic [CNT_W-1:0]                    o_sat_cnt
);

    localparam int WW = 2 * DATA_WIDTH;

    // Clamp bounds, held at the rounded-result width so that both comparisons are signed.
    localparam logic signed [WW:0] SAT_MAX = (WW+1)'((2 ** (DATA_WIDTH - 1)) - 1);
    localparam logic signed [WW:0] SAT_MIN = (WW+1)'(-(2 ** (DATA_WIDTH - 1)));

    logic                                s1_vld;
    logic [DATA_COPIES*WW-1:0]           s1_data;
    logic [SHIFT_W-1:0]                  s1_shift;
    logic                                relu_active;
    logic                                s2_vld;
    logic                                s2_en;
    logic [SHIFT_W-1:0]                  eff_shift;
    logic [DATA_COPIES*DATA_WIDTH-1:0]   nar_data;
    logic [DATA_COPIES-1:0]              nar_sat;

`ifdef PE_REQUANT_RELU_EN
    logic                                s1_relu;
`endif

    // Narrow one lane. The result is {sat_flag, narrowed_value}.
    // The rounding add is done one bit wider than the lane, so x + 2^(s-1) cannot wrap.
    function automatic logic [DATA_WIDTH:0] narrow_lane(
        input logic [WW-1:0]      x,
        input logic [SHIFT_W-1:0] s,
        input logic               zero_neg
    );
        logic signed [WW:0]      ext;
        logic signed [WW:0]      rnd;
        logic signed [WW:0]      sum;
        logic signed [WW:0]      shr;
        logic [DATA_WIDTH-1:0]   res;
        logic                    sat;
        if (zero_neg && x[WW-1]) begin
            ext = '0;
        end else begin
            ext = {x[WW-1], x};
        end
        if (s == '0) begin
            rnd = '0;
        end else begin
            rnd = (WW+1)'(1) << (s - SHIFT_W'(1));
        end
        sum = ext + rnd;
        shr = sum >>> s;
        if (shr > SAT_MAX) begin
            res = SAT_MAX[DATA_WIDTH-1:0];
            sat = 1'b1;
        end else if (shr < SAT_MIN) begin
            res = SAT_MIN[DATA_WIDTH-1:0];
            sat = 1'b1;
        end else begin
            res = shr[DATA_WIDTH-1:0];
            sat = 1'b0;
        end
        return {sat, res};
    endfunction

    // S2 can take a new beat when it is empty or is draining this cycle.
    // S1 can take a new beat when it is empty or is moving into S2.
    assign s2_en     = !s2_vld || i_out_rdy;
    assign o_in_rdy  = !s1_vld || s2_en;
    assign o_out_vld = s2_vld;

`ifdef PE_REQUANT_RELU_EN
    assign relu_active = s1_relu;
`else
    assign relu_active = 1'b0;
`endif

    // Shift amounts beyond the lane width collapse to the largest legal shift.
    always_comb begin
        eff_shift = s1_shift;
        if (int'(s1_shift) > WW - 1) begin
            eff_shift = SHIFT_W'(WW - 1);
        end
    end

    // Round, shift and clamp every lane of the beat held in S1.
    always_comb begin
        nar_data = '0;
        nar_sat  = '0;
        for (int i = 0; i < DATA_COPIES; i++) begin
            {nar_sat[i], nar_data[DATA_WIDTH*i +: DATA_WIDTH]} =
                narrow_lane(s1_data[WW*i +: WW], eff_shift, relu_active);
        end
    end

    // Stage 1: capture the wide lanes and the per-beat controls on each input handshake.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_vld   <= 1'b0;
            s1_data  <= '0;
            s1_shift <= '0;
        end else if (o_in_rdy) begin
            s1_vld <= i_in_vld;
            if (i_in_vld) begin
                s1_data  <= i_in_data;
                s1_shift <= i_shift;
            end
        end
    end

`ifdef PE_REQUANT_RELU_EN
    // The ReLU select travels with its beat through stage 1.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_relu <= 1'b0;
        end else if (o_in_rdy && i_in_vld) begin
            s1_relu <= i_relu_en;
        end
    end
`endif

    // Stage 2: register the narrowed lanes. The output holds steady while it is stalled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s2_vld     <= 1'b0;
            o_out_data <= '0;
            o_out_sat  <= '0;
        end else if (s2_en) begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                o_out_data <= nar_data;
                o_out_sat  <= nar_sat;
            end
        end
    end

    // Count delivered beats that had any clamped lane. The count sticks at all-ones,
    // and a clear takes priority over an increment in the same cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_sat_cnt <= '0;
        end else if (i_sat_clr) begin
            o_sat_cnt <= '0;
        end else if (s2_vld && i_out_rdy && (|o_out_sat) && (o_sat_cnt != '1)) begin
            o_sat_cnt <= o_sat_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pe_add_requant.sv
// tb_pe_add_requant: bench for pe_add_requant with default parameters.
// It combines hand-computed vectors, multi-cycle corner sequences and randomized
// traffic. The randomized traffic is checked against a real-arithmetic reference model.
module tb_pe_add_requant;

    localparam int W      = 8;
    localparam int N      = 32;
    localparam int WW     = 2 * W;
    localparam int WIDE   = N * WW;
    localparam int NARROW = N * W;
    localparam int CW     = 16;
    localparam longint MAXV = (longint'(1) << (W - 1)) - 1;
    localparam longint MINV = -(longint'(1) << (W - 1));

    typedef struct packed {
        logic [NARROW-1:0] data;
        logic [N-1:0]      sat;
    } exp_t;

    typedef struct packed {
        logic [3:0][15:0] x;
        logic [3:0]       s;
        logic [3:0][7:0]  y;
        logic [3:0]       sat;
    } vec_t;

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b1;
    logic [WIDE-1:0]   i_in_data = '0;
    logic              i_in_vld = 1'b0;
    logic              o_in_rdy;
    logic [3:0]        i_shift = '0;
    logic [NARROW-1:0] o_out_data;
    logic [N-1:0]      o_out_sat;
    logic              o_out_vld;
    logic              i_out_rdy = 1'b1;
    logic              i_sat_clr = 1'b0;
    logic [CW-1:0]     o_sat_cnt;
    logic              relu_drv = 1'b0;

    int          total = 0;
    int          bad = 0;
    exp_t        q[$];
    logic [CW-1:0] model_cnt = '0;
    logic        rdy_seen;
    logic        vld_seen;
    vec_t        tbl[6];

    pe_add_requant dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_in_data  (i_in_data),
        .i_in_vld   (i_in_vld),
        .o_in_rdy   (o_in_rdy),
        .i_shift    (i_shift),
        .o_out_data (o_out_data),
        .o_out_sat  (o_out_sat),
        .o_out_vld  (o_out_vld),
        .i_out_rdy  (i_out_rdy),
        .i_sat_clr  (i_sat_clr),
`ifdef PE_REQUANT_RELU_EN
        .i_relu_en  (relu_drv),
`endif
        .o_sat_cnt  (o_sat_cnt)
    );

    always #5 i_clk = ~i_clk;

    // Guard against a stuck run.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Reference: x / 2^s rounded half toward +inf, optional ReLU, then clamped.
    function automatic exp_t model_beat(input logic [WIDE-1:0] data, input int sh, input logic relu);
        exp_t   e;
        int     s;
        longint x;
        longint r;
        e = '0;
        s = (sh > WW - 1) ? WW - 1 : sh;
        for (int i = 0; i < N; i++) begin
            x = longint'($signed(data[WW*i +: WW]));
            if (relu && x < 0) x = 0;
            r = longint'($floor(real'(x) / (2.0 ** s) + 0.5));
            if (r > MAXV) begin
                r = MAXV;
                e.sat[i] = 1'b1;
            end else if (r < MINV) begin
                r = MINV;
                e.sat[i] = 1'b1;
            end
            e.data[W*i +: W] = r[W-1:0];
        end
        return e;
    endfunction

    function automatic logic [WIDE-1:0] rand_wide();
        logic [WIDE-1:0] d;
        d = '0;
        for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 2))
                0:       d[WW*i +: WW] = 16'($urandom_range(0, 400)) - 16'd200;
                1:       d[WW*i +: WW] = 16'($urandom);
                default: d[WW*i +: WW] = 16'($urandom_range(0, 4095)) - 16'd2048;
            endcase
        end
        return d;
    endfunction

    task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic failNote(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s", name);
    endtask

    // Drive one cycle of inputs, score the output side, and advance the reference.
    task automatic applyStimulus(input logic vld, input logic [WIDE-1:0] data, input logic [3:0] sh,
                                 input logic relu, input logic ordy, input logic clr);
        logic hs_out;
        logic popped_sat;
        @(negedge i_clk);
        i_in_vld  = vld;
        i_in_data = data;
        i_shift   = sh;
        relu_drv  = relu;
        i_out_rdy = ordy;
        i_sat_clr = clr;
        #2;
        checkOutput("sat_cnt", o_sat_cnt, model_cnt);
        rdy_seen   = o_in_rdy;
        vld_seen   = o_out_vld;
        hs_out     = o_out_vld && i_out_rdy;
        popped_sat = 1'b0;
        if (o_out_vld) begin
            if (q.size() == 0) begin
                failNote("spurious output beat");
            end else begin
                checkOutput("out_data", o_out_data, q[0].data);
                checkOutput("out_sat", o_out_sat, q[0].sat);
                if (hs_out) begin
                    popped_sat = (q[0].sat != '0);
                    void'(q.pop_front());
                end
            end
        end
        if (vld && o_in_rdy) q.push_back(model_beat(data, int'(sh), relu));
        if (clr) model_cnt = '0;
        else if (hs_out && popped_sat && model_cnt != '1) model_cnt = model_cnt + 1'b1;
        @(posedge i_clk);
    endtask

    // One isolated beat with explicit expected lanes 0..3 (all other lanes are zero).
    task automatic runVector(input string name, input logic [3:0][15:0] x, input logic [3:0] s,
                             input logic relu, input logic [3:0][7:0] y, input logic [3:0] sat);
        logic [WIDE-1:0] d;
        d = '0;
        for (int i = 0; i < 4; i++) d[WW*i +: WW] = x[i];
        applyStimulus(1'b1, d, s, relu, 1'b1, 1'b0);
        checkOutput({name, " accepted"}, rdy_seen, 1);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        checkOutput({name, " latency gap"}, vld_seen, 0);
        #2;
        checkOutput({name, " valid"}, o_out_vld, 1);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("%s lane%0d", name, i), o_out_data[W*i +: W], y[i]);
        checkOutput({name, " upper lanes"}, o_out_data[NARROW-1:32], 0);
        checkOutput({name, " sat"}, o_out_sat[3:0], sat);
        checkOutput({name, " upper sat"}, o_out_sat[N-1:4], 0);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [WIDE-1:0] b0, b1, b2, d;
        logic            relu;
        logic [CW-1:0]   tbl_cnt;

        tbl[0].x = {-16'sd5, 16'sd5, -16'sd300, 16'sd300};
        tbl[0].s = 4'd1; tbl[0].y = {8'hFE, 8'h03, 8'h80, 8'h7F}; tbl[0].sat = 4'b0011;
        tbl[1].x = {-16'sd129, 16'sd128, -16'sd128, 16'sd127};
        tbl[1].s = 4'd0; tbl[1].y = {8'h80, 8'h7F, 8'h80, 8'h7F}; tbl[1].sat = 4'b1100;
        tbl[2].x = {-16'sd1, 16'sd1, 16'sd0, -16'sd7};
        tbl[2].s = 4'd2; tbl[2].y = {8'h00, 8'h00, 8'h00, 8'hFE}; tbl[2].sat = 4'b0000;
        tbl[3].x = {-16'sd16384, 16'sd16384, 16'h8000, 16'sd32767};
        tbl[3].s = 4'd15; tbl[3].y = {8'h00, 8'h01, 8'hFF, 8'h01}; tbl[3].sat = 4'b0000;
        tbl[4].x = {-16'sd2056, -16'sd2048, 16'sd2047, 16'sd2040};
        tbl[4].s = 4'd4; tbl[4].y = {8'h80, 8'h80, 8'h7F, 8'h7F}; tbl[4].sat = 4'b0011;
        tbl[5].x = {16'sd3, -16'sd5, -16'sd4, -16'sd1};
        tbl[5].s = 4'd3; tbl[5].y = {8'h00, 8'hFF, 8'h00, 8'h00}; tbl[5].sat = 4'b0000;

        // Reset values.
        #1 i_rst_n = 1'b0;
        #2;
        checkOutput("reset out_vld", o_out_vld, 0);
        checkOutput("reset out_data", o_out_data, 0);
        checkOutput("reset out_sat", o_out_sat, 0);
        checkOutput("reset sat_cnt", o_sat_cnt, 0);
        checkOutput("reset in_rdy", o_in_rdy, 1);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Hand-computed vectors.
        tbl_cnt = '0;
        for (int k = 0; k < 6; k++) begin
            runVector($sformatf("vec%0d", k), tbl[k].x, tbl[k].s, 1'b0, tbl[k].y, tbl[k].sat);
            if (tbl[k].sat != '0) tbl_cnt = tbl_cnt + 1'b1;
            #2;
            checkOutput($sformatf("vec%0d count", k), o_sat_cnt, tbl_cnt);
        end

        // Back-pressure: the third beat must wait. Releasing ready with the pipeline full
        // pops and pushes in the same cycle.
        b0 = rand_wide(); b1 = rand_wide(); b2 = rand_wide();
        applyStimulus(1'b1, b0, 4'd2, 1'b0, 1'b0, 1'b0);
        checkOutput("stall rdy beat0", rdy_seen, 1);
        applyStimulus(1'b1, b1, 4'd5, 1'b0, 1'b0, 1'b0);
        checkOutput("stall rdy beat1", rdy_seen, 1);
        applyStimulus(1'b1, b2, 4'd7, 1'b0, 1'b0, 1'b0);
        checkOutput("stall rdy full", rdy_seen, 0);
        checkOutput("stall out_vld", vld_seen, 1);
        applyStimulus(1'b1, b2, 4'd7, 1'b0, 1'b0, 1'b0);
        checkOutput("stall rdy still full", rdy_seen, 0);
        applyStimulus(1'b1, b2, 4'd7, 1'b0, 1'b1, 1'b0);
        checkOutput("full pop+push rdy", rdy_seen, 1);
        for (int k = 0; k < 4; k++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        checkOutput("stall drained", q.size(), 0);

        // Randomized traffic with random back-pressure and occasional counter clears.
        for (int k = 0; k < 600; k++) begin
`ifdef PE_REQUANT_RELU_EN
            relu = 1'($urandom_range(0, 1));
`else
            relu = 1'b0;
`endif
            applyStimulus(($urandom_range(0, 3) != 0), rand_wide(), 4'($urandom_range(0, 15)), relu,
                          ($urandom_range(0, 3) != 0), ($urandom_range(0, 24) == 0));
        end
        for (int k = 0; k < 4; k++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        checkOutput("random drained", q.size(), 0);

`ifdef PE_REQUANT_RELU_EN
        runVector("relu", {16'd0, 16'd0, 16'sd300, -16'sd300}, 4'd0, 1'b1,
                  {8'h00, 8'h00, 8'h7F, 8'h00}, 4'b0010);
`endif

        // Counter saturation: it sticks at all-ones, and a clear beats a same-cycle increment.
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 65540; k++) begin
            d = rand_wide();
            d[WW-1:0] = 16'sd1000;
            applyStimulus(1'b1, d, 4'd0, 1'b0, 1'b1, 1'b0);
        end
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        #2;
        checkOutput("count sticks", o_sat_cnt, 16'hFFFF);
        d = rand_wide();
        d[WW-1:0] = -16'sd1000;
        applyStimulus(1'b1, d, 4'd0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        #2;
        checkOutput("clear beats increment", o_sat_cnt, 0);

        // Reset while both stages are full.
        applyStimulus(1'b1, d, 4'd0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        #2;
        checkOutput("pre-reset count", o_sat_cnt, 1);
        applyStimulus(1'b1, rand_wide(), 4'd1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, rand_wide(), 4'd1, 1'b0, 1'b0, 1'b0);
        @(negedge i_clk);
        i_in_vld = 1'b0;
        #2 i_rst_n = 1'b0;
        #1;
        checkOutput("midreset out_vld", o_out_vld, 0);
        checkOutput("midreset in_rdy", o_in_rdy, 1);
        checkOutput("midreset sat_cnt", o_sat_cnt, 0);
        checkOutput("midreset out_data", o_out_data, 0);
        q.delete();
        model_cnt = '0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        runVector("post-reset", {16'd0, 16'd0, 16'd0, -16'sd7}, 4'd2, 1'b0,
                  {8'h00, 8'h00, 8'h00, 8'hFE}, 4'b0000);
        checkOutput("final drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
